// File: rtl/artix_spi_master.sv
// ---------------------------------------------------------------------------
// artix_spi_master
//
// Turns host register commands (address, write data, go) into 32-bit SPI
// frames for the Artix front-end FPGA and captures the word returned on MISO.
// SPI mode 0 (sclk idles low, data sampled on the rising edge), MSB first,
// single chip select. The frame is {spi_addr, spi_wdata}; bit 7 of the address
// marks a read, but the write data is shifted out either way.
//
// Ports
//   aclk          system clock
//   aresetn       asynchronous active-low reset, released synchronously
//   spi_addr      register address, latched on the go edge
//   spi_wdata     write data, latched on the go edge
//   spi_go        level from the go register; each rising edge requests a frame
//   err_clr       one-cycle pulse that clears err_overrun
//   spi_sclk      SPI clock (registered)
//   spi_cs_n      chip select, active low (registered)
//   spi_mosi      serial data out (registered)
//   spi_miso      serial data in, already synchronised at the pin
//   spi_rdata     MISO word of the last completed frame
//   busy          high from the cycle after the go edge until the gap ends
//   done          one-cycle pulse in the cycle cs_n returns high
//   err_overrun   sticky flag: a go edge arrived while busy
// ---------------------------------------------------------------------------
module artix_spi_master #(
   parameter int CLK_DIV    = 10,
   parameter int FRAME_BITS = 32
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [7:0]            spi_addr,
   input  logic [23:0]           spi_wdata,
   input  logic                  spi_go,
   input  logic                  err_clr,
   output logic                  spi_sclk,
   output logic                  spi_cs_n,
   output logic                  spi_mosi,
   input  logic                  spi_miso,
   output logic [FRAME_BITS-1:0] spi_rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err_overrun
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(FRAME_BITS);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

   state_e                state_q, state_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;
   logic [FRAME_BITS-1:0] rsh_q, rsh_d;
   logic [FRAME_BITS-1:0] rdata_q, rdata_d;
   logic                  sclk_q, sclk_d;
   logic                  cs_n_q, cs_n_d;
   logic                  mosi_q, mosi_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  go_q, go_d;
   logic                  pend_q, pend_d;

   logic                  go_rise;
   logic                  div_last;

   assign go_rise  = spi_go & ~go_q;
   assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

   // All state, including the pin drivers, lives in this one register bank so
   // every SPI pin comes straight from a flop and reset aborts a frame at once.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         rsh_q   <= '0;
         rdata_q <= '0;
         sclk_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         go_q    <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         rsh_q   <= rsh_d;
         rdata_q <= rdata_d;
         sclk_q  <= sclk_d;
         cs_n_q  <= cs_n_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         go_q    <= go_d;
         pend_q  <= pend_d;
      end
   end

   // Next-state logic. A go edge in IDLE latches the command and raises busy;
   // the following cycle (pend) drops cs_n and presents the MSB, so cs_n falls
   // two clocks after the go register changes. Each phase (setup, sclk low,
   // sclk high, hold, gap) lasts CLK_DIV cycles, timed by div_q.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      rsh_d   = rsh_q;
      rdata_d = rdata_q;
      sclk_d  = sclk_q;
      cs_n_d  = cs_n_q;
      mosi_d  = mosi_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      go_d    = spi_go;
      pend_d  = 1'b0;

      // A go edge while busy is dropped; setting beats a simultaneous clear.
      if (go_rise && busy_q) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (pend_q) begin
               state_d = SETUP;
               div_d   = '0;
               cs_n_d  = 1'b0;
               mosi_d  = shreg_q[FRAME_BITS-1];
            end else if (go_rise && !busy_q) begin
               shreg_d = {spi_addr, spi_wdata};
               busy_d  = 1'b1;
               pend_d  = 1'b1;
            end
         end
         SETUP: begin
            if (div_last) begin
               div_d   = '0;
               bit_d   = BIT_W'(FRAME_BITS - 1);
               state_d = SHIFT;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         SHIFT: begin
            if (div_last) begin
               div_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  rsh_d  = {rsh_q[FRAME_BITS-2:0], spi_miso};
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q == '0) begin
                     state_d = HOLD;
                  end else begin
                     bit_d   = bit_q - 1'b1;
                     shreg_d = shreg_q << 1;
                     mosi_d  = shreg_q[FRAME_BITS-2];
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         HOLD: begin
            if (div_last) begin
               div_d   = '0;
               cs_n_d  = 1'b1;
               mosi_d  = 1'b0;
               done_d  = 1'b1;
               rdata_d = rsh_q;
               state_d = GAP;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         GAP: begin
            if (div_last) begin
               div_d   = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign spi_sclk    = sclk_q;
   assign spi_cs_n    = cs_n_q;
   assign spi_mosi    = mosi_q;
   assign spi_rdata   = rdata_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err_overrun = err_q;

endmodule

// File: tb/tb_artix_spi_master.sv
// ---------------------------------------------------------------------------
// tb_artix_spi_master
//
// Self-checking bench for artix_spi_master. A mode-0 slave model returns a
// chosen word on MISO; a pin monitor rebuilds each MOSI frame, checks the
// SPI timing and pops the expected frame/readback from a scoreboard queue on
// every done pulse. Table-driven frames plus hand-written corner sequences
// (go timing, overrun, held go, mid-frame reset).
// ---------------------------------------------------------------------------
module tb_artix_spi_master;

   localparam int CLK_DIV   = 10;
   localparam int FRAME_LEN = CLK_DIV * (2 + 2 * 32);

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [7:0]  spi_addr = '0;
   logic [23:0] spi_wdata = '0;
   logic        spi_go = 1'b0;
   logic        err_clr = 1'b0;
   logic        spi_sclk;
   logic        spi_cs_n;
   logic        spi_mosi;
   logic        spi_miso = 1'b0;
   logic [31:0] spi_rdata;
   logic        busy;
   logic        done;
   logic        err_overrun;

   artix_spi_master #(.CLK_DIV(CLK_DIV), .FRAME_BITS(32)) dut (
      .aclk(aclk), .aresetn(aresetn), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
      .spi_go(spi_go), .err_clr(err_clr), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_rdata(spi_rdata), .busy(busy),
      .done(done), .err_overrun(err_overrun)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [7:0]  addr;
      logic [23:0] wdata;
      logic [31:0] miso;
      logic [31:0] expFrame;
   } vector_t;

   typedef struct packed {
      logic [31:0] frame;
      logic [31:0] rdata;
   } expect_t;

   expect_t expQ[$];
   expect_t monE;

   int assertCount = 0;
   int failCount   = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic checkAtLeast(input string name, input int actual, input int minimum);
      assertCount++;
      if (actual < minimum) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d cycles, expected at least %0d", name, actual, minimum);
      end
   endtask

   // Mode-0 slave: present the MSB when cs_n falls, next bit after each sclk fall.
   logic [31:0] misoWord = '0;
   logic [31:0] slaveWord = '0;
   int          slaveIdx = 0;
   bit          inFrame = 0;

   always @(spi_cs_n or negedge spi_sclk) begin
      if (spi_cs_n !== 1'b0) begin
         inFrame = 0;
      end else if (!inFrame) begin
         inFrame   = 1;
         slaveWord = misoWord;
         slaveIdx  = 31;
         spi_miso  = slaveWord[31];
      end else if (spi_sclk == 1'b0 && slaveIdx > 0) begin
         slaveIdx--;
         spi_miso = slaveWord[slaveIdx];
      end
   end

   // Pin monitor, sampled on the falling aclk edge (away from the active edge).
   int          cyc = 0;
   int          tCsFall = 0, tCsRise = 0, tRise = 0, tFall = 0, tMosi = 0;
   int          bitsSeen = 0;
   int          frames = 0;
   int          dones = 0;
   bit          prevFrame = 0;
   logic [31:0] frameSh = '0;
   logic        pSclk = 1'b0, pCs = 1'b1, pMosi = 1'b0;

   always @(negedge aclk) begin
      cyc++;
      if (!aresetn) begin
         prevFrame = 0;
         bitsSeen  = 0;
      end else begin
         if (pMosi !== spi_mosi) begin
            tMosi = cyc;
            checkOutput("mosi_change_while_sclk_low", 32'(spi_sclk), 32'd0);
         end
         if (pCs && !spi_cs_n) begin
            if (prevFrame) checkAtLeast("cs_gap", cyc - tCsRise, CLK_DIV);
            tCsFall  = cyc;
            bitsSeen = 0;
            frames++;
         end
         if (!pSclk && spi_sclk) begin
            checkAtLeast("mosi_setup", cyc - tMosi, CLK_DIV);
            if (bitsSeen == 0) checkOutput("setup_cycles", 32'(cyc - tCsFall), 32'(2 * CLK_DIV));
            else               checkOutput("sclk_period", 32'(cyc - tRise), 32'(2 * CLK_DIV));
            frameSh = {frameSh[30:0], spi_mosi};
            bitsSeen++;
            tRise = cyc;
         end
         if (pSclk && !spi_sclk) begin
            checkOutput("sclk_high_cycles", 32'(cyc - tRise), 32'(CLK_DIV));
            tFall = cyc;
         end
         if (!pCs && spi_cs_n) begin
            checkOutput("hold_cycles", 32'(cyc - tFall), 32'(CLK_DIV));
            checkOutput("cs_low_length", 32'(cyc - tCsFall), 32'(FRAME_LEN));
            checkOutput("frame_bits", 32'(bitsSeen), 32'd32);
            tCsRise   = cyc;
            prevFrame = 1;
         end
         if (done) begin
            dones++;
            checkOutput("done_with_cs_high", 32'(spi_cs_n), 32'd1);
            checkOutput("expected_frame_queued", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
               monE = expQ.pop_front();
               checkOutput("mosi_frame", frameSh, monE.frame);
               checkOutput("rdata_on_done", spi_rdata, monE.rdata);
            end
         end
      end
      pSclk = spi_sclk;
      pCs   = spi_cs_n;
      pMosi = spi_mosi;
   end

   // One go write (1 then 0); optionally scores the frame; scrambles inputs after.
   task automatic applyStimulus(input logic [7:0] addr, input logic [23:0] wdata,
                                input logic [31:0] miso, input logic [31:0] expFrame,
                                input bit expectIt);
      @(negedge aclk);
      spi_addr  = addr;
      spi_wdata = wdata;
      if (expectIt) begin
         misoWord = miso;
         expQ.push_back('{frame: expFrame, rdata: miso});
      end
      spi_go = 1'b1;
      @(negedge aclk);
      spi_go    = 1'b0;
      spi_addr  = 8'($urandom);
      spi_wdata = 24'($urandom);
   endtask

   task automatic waitIdle(input int maxCycles);
      int n = 0;
      while (busy && n < maxCycles) begin
         @(negedge aclk);
         n++;
      end
      if (busy) checkOutput("busy_clear_timeout", 32'(busy), 32'd0);
   endtask

   task automatic waitDone(input int maxCycles);
      int n = 0;
      while (!done && n < maxCycles) begin
         @(negedge aclk);
         n++;
      end
      if (!done) checkOutput("done_timeout", 32'(done), 32'd1);
   endtask

   vector_t vecs[4];
   int      d0, f0;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{addr: 8'h02, wdata: 24'h000005, miso: 32'h12345678, expFrame: 32'h02000005};
      vecs[1] = '{addr: 8'h80, wdata: 24'hABCDEF, miso: 32'hFFFFFFFF, expFrame: 32'h80ABCDEF};
      vecs[2] = '{addr: 8'h7F, wdata: 24'hFFFFFF, miso: 32'h00000000, expFrame: 32'h7FFFFFFF};
      vecs[3] = '{addr: 8'h55, wdata: 24'hAAAAAA, miso: 32'h80000001, expFrame: 32'h55AAAAAA};

      // Reset state
      repeat (3) @(negedge aclk);
      checkOutput("rst_sclk", 32'(spi_sclk), 32'd0);
      checkOutput("rst_cs_n", 32'(spi_cs_n), 32'd1);
      checkOutput("rst_mosi", 32'(spi_mosi), 32'd0);
      checkOutput("rst_rdata", spi_rdata, 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err", 32'(err_overrun), 32'd0);
      aresetn = 1'b1;
      repeat (3) @(negedge aclk);

      // First frame: cs_n falls two clocks after go, readback 0xA5C30F96
      $display("[TB] frame 0x01000003 with readback 0xA5C30F96");
      spi_addr  = 8'h01;
      spi_wdata = 24'h000003;
      misoWord  = 32'hA5C30F96;
      expQ.push_back('{frame: 32'h01000003, rdata: 32'hA5C30F96});
      spi_go = 1'b1;
      @(posedge aclk); #1;
      checkOutput("cs_n_1clk_after_go", 32'(spi_cs_n), 32'd1);
      checkOutput("busy_1clk_after_go", 32'(busy), 32'd1);
      @(posedge aclk); #1;
      checkOutput("cs_n_2clk_after_go", 32'(spi_cs_n), 32'd0);
      @(negedge aclk);
      spi_go = 1'b0;
      waitIdle(2000);
      repeat (50) @(negedge aclk);
      #1;
      checkOutput("first_done_count", 32'(dones), 32'd1);
      checkOutput("rdata_held_idle", spi_rdata, 32'hA5C30F96);

      // Table of frames
      for (int i = 0; i < 4; i++) begin
         d0 = dones;
         applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].miso, vecs[i].expFrame, 1'b1);
         waitIdle(2000);
         repeat (30) @(negedge aclk);
         #1;
         checkOutput("vec_done_count", 32'(dones - d0), 32'd1);
         checkOutput("vec_rdata_held", spi_rdata, vecs[i].miso);
      end

      // Overrun: go during GAP is dropped and flagged
      $display("[TB] overrun during gap");
      applyStimulus(8'h01, 24'h000003, 32'h0F0F0F0F, 32'h01000003, 1'b1);
      waitDone(1000);
      spi_addr  = 8'h02;
      spi_wdata = 24'h000005;
      spi_go    = 1'b1;
      @(negedge aclk);
      spi_go = 1'b0;
      checkOutput("err_after_gap_go", 32'(err_overrun), 32'd1);
      waitIdle(2000);
      #1;
      f0 = frames;
      repeat (100) @(negedge aclk);
      #1;
      checkOutput("dropped_frame_not_sent", 32'(frames - f0), 32'd0);
      err_clr = 1'b1;
      @(negedge aclk);
      err_clr = 1'b0;
      checkOutput("err_cleared", 32'(err_overrun), 32'd0);

      // Reissue, with a simultaneous go edge + err_clr mid-frame (set wins)
      applyStimulus(8'h02, 24'h000005, 32'h13572468, 32'h02000005, 1'b1);
      repeat (20) @(negedge aclk);
      spi_go  = 1'b1;
      err_clr = 1'b1;
      @(negedge aclk);
      spi_go  = 1'b0;
      err_clr = 1'b0;
      checkOutput("err_set_wins", 32'(err_overrun), 32'd1);
      waitIdle(2000);
      err_clr = 1'b1;
      @(negedge aclk);
      err_clr = 1'b0;
      checkOutput("err_cleared_again", 32'(err_overrun), 32'd0);
      checkOutput("reissue_rdata", spi_rdata, 32'h13572468);

      // go held high for 2000 cycles -> exactly one frame
      $display("[TB] go held high");
      @(negedge aclk);
      #1;
      f0 = frames;
      d0 = dones;
      spi_addr  = 8'h3C;
      spi_wdata = 24'h00F00F;
      misoWord  = 32'hDEADBEEF;
      expQ.push_back('{frame: 32'h3C00F00F, rdata: 32'hDEADBEEF});
      spi_go = 1'b1;
      repeat (2000) @(negedge aclk);
      spi_go = 1'b0;
      waitIdle(2000);
      repeat (20) @(negedge aclk);
      #1;
      checkOutput("held_go_frames", 32'(frames - f0), 32'd1);
      checkOutput("held_go_dones", 32'(dones - d0), 32'd1);

      // Reset at bit 12 aborts at once; next frame is complete
      $display("[TB] reset mid-frame");
      applyStimulus(8'h5A, 24'h123456, 32'h0000FFFF, 32'h5A123456, 1'b1);
      begin
         int n = 0;
         while (bitsSeen < 12 && n < 1000) begin
            @(posedge aclk);
            n++;
         end
         if (bitsSeen < 12) checkOutput("bit12_timeout", 32'(bitsSeen), 32'd12);
      end
      #1;
      aresetn = 1'b0;
      #1;
      checkOutput("abort_cs_n", 32'(spi_cs_n), 32'd1);
      checkOutput("abort_sclk", 32'(spi_sclk), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_rdata_is_reset", spi_rdata, 32'd0);
      expQ.delete();
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      repeat (3) @(negedge aclk);
      d0 = dones;
      applyStimulus(8'h81, 24'h000000, 32'hFFFF0000, 32'h81000000, 1'b1);
      waitIdle(2000);
      repeat (10) @(negedge aclk);
      #1;
      checkOutput("post_abort_dones", 32'(dones - d0), 32'd1);
      checkOutput("post_abort_rdata", spi_rdata, 32'hFFFF0000);
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
